apb_uart: RTL

APB slave UART (8N1) with TX and RX FIFOs. It sits directly downstream of the CPU's APB master port and completes the CPU's load/store transfers to the UART address window. It serialises bytes stored by the CPU onto `uart_tx`, deserialises `uart_rx` into a FIFO the CPU drains with loads, and raises a level interrupt.

---
 rtl/apb_uart_pkg.sv | 38 +++
 rtl/apb_uart_sync_fifo.sv | 68 ++++++
 rtl/apb_uart.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_pkg: register map, STATUS bit positions and engine state encodings    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package uart_pkg;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_DIV    = 2'd2;
   localparam logic [1:0] REG_IRQ_EN = 2'd3;

   localparam int ST_TX_FULL    = 0;
   localparam int ST_TX_EMPTY   = 1;
   localparam int ST_RX_EMPTY   = 2;
   localparam int ST_RX_FULL    = 3;
   localparam int ST_RX_OVERRUN = 4;
   localparam int ST_FRAME_ERR  = 5;
   localparam int ST_TX_BUSY    = 6;

   localparam logic [15:0] DIV_MIN = 16'd4;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/apb_uart_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_fifo: single-clock FIFO; a pop frees a slot for a same-edge push      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rts_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      do_pop   = pop & (count_q != '0);
      do_push  = push & ((count_q != FULL_CNT) | do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rts_n) begin
      if (!rts_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the pointers alone define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/apb_uart.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | apb_uart: APB slave 8N1 UART with TX/RX FIFOs and a level interrupt        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module apb_uart
   import uart_pkg::*;
#(
   parameter int          APB_paddr_WIDTH = 32,
   parameter int          DATA_WIDTH      = 32,
   parameter int          FIFO_DEPTH      = 8,
   parameter logic [15:0] DIV_RESET       = 16'd434
) (
   input  logic                       clk,
   input  logic                       rts_n,
   input  logic [APB_paddr_WIDTH-1:0] APB_paddr,
   input  logic [DATA_WIDTH-1:0]      APB_pdata,
   output logic [DATA_WIDTH-1:0]      APB_prdata,
   input  logic                       APB_psel,
   input  logic                       APB_penable,
   input  logic                       APB_pwrite,
   input  logic [3:0]                 APB_pstb,
   output logic                       APB_pready,
   output logic                       APB_perr,
   output logic                       uart_tx,
   input  logic                       uart_rx,
   output logic                       irq
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [1:0]            reg_addr;
   logic                  access, data_wr, wr_ok, rd_ok, w1c;
   logic [6:0]            status;
   logic [DATA_WIDTH-1:0] rdata;
   logic [15:0]           div_wr;

   logic            tx_push, tx_pop, tx_full, tx_empty;
   logic [7:0]      tx_dout;
   logic [CW-1:0]   tx_count;
   logic            rx_pop, rx_full, rx_empty;
   logic [7:0]      rx_dout;
   logic [CW-1:0]   rx_count;

   logic [15:0] div_q, div_d;
   logic [1:0]  irq_en_q, irq_en_d;
   logic        overrun_q, overrun_d, overrun_set;
   logic        frame_err_q, frame_err_d;
   logic        irq_q, irq_d;

   tx_state_e   tx_state_q;
   logic [15:0] tx_cnt_q, tx_div_q;
   logic [7:0]  tx_shift_q;
   logic [2:0]  tx_bit_q;
   logic        uart_tx_q;

   rx_state_e   rx_state_q;
   logic [15:0] rx_cnt_q, rx_div_q;
   logic [7:0]  rx_shift_q;
   logic [2:0]  rx_bit_q;
   logic        rx_s1_q, rx_s2_q, rx_prev_q;
   logic        rx_push_q, frame_set_q;

   // ---------------------------------------------------------------- APB decode
   always_comb begin
      reg_addr   = APB_paddr[3:2];
      access     = APB_psel & APB_penable;
      APB_perr   = access & APB_pwrite & ~APB_pstb[0];
      data_wr    = access & APB_pwrite & APB_pstb[0] & (reg_addr == REG_DATA);
      APB_pready = access & ~(data_wr & tx_full);
      wr_ok      = APB_pready & APB_pwrite & APB_pstb[0];
      rd_ok      = APB_pready & ~APB_pwrite;
      w1c        = wr_ok & (reg_addr == REG_STATUS);
      tx_push    = wr_ok & (reg_addr == REG_DATA);
      rx_pop     = rd_ok & (reg_addr == REG_DATA) & ~rx_empty;

      status                = '0;
      status[ST_TX_FULL]    = tx_full;
      status[ST_TX_EMPTY]   = tx_empty;
      status[ST_RX_EMPTY]   = rx_empty;
      status[ST_RX_FULL]    = rx_full;
      status[ST_RX_OVERRUN] = overrun_q;
      status[ST_FRAME_ERR]  = frame_err_q;
      status[ST_TX_BUSY]    = (tx_state_q != TX_IDLE);

      rdata = '0;
      case (reg_addr)
         REG_DATA: begin
            if (!rx_empty) begin
               rdata[7:0] = rx_dout;
               rdata[8]   = 1'b1;
            end
         end
         REG_STATUS: rdata[6:0]  = status;
         REG_DIV:    rdata[15:0] = div_q;
         default:    rdata[1:0]  = irq_en_q;
      endcase
      APB_prdata = rd_ok ? rdata : '0;
   end

   // ---------------------------------------------------------------- registers
   always_comb begin
      div_wr = div_q;
      div_wr[7:0] = APB_pdata[7:0];
      if (APB_pstb[1]) div_wr[15:8] = APB_pdata[15:8];

      div_d = div_q;
      if (wr_ok && reg_addr == REG_DIV) div_d = (div_wr < DIV_MIN) ? DIV_MIN : div_wr;

      irq_en_d = irq_en_q;
      if (wr_ok && reg_addr == REG_IRQ_EN) irq_en_d = APB_pdata[1:0];

      // A drop only counts as overrun when no same-edge pop frees a slot.
      overrun_set = rx_push_q & rx_full & ~rx_pop;
      overrun_d   = (overrun_q & ~(w1c & APB_pdata[ST_RX_OVERRUN])) | overrun_set;
      frame_err_d = (frame_err_q & ~(w1c & APB_pdata[ST_FRAME_ERR])) | frame_set_q;

      irq_d = (irq_en_q[0] & ~rx_empty) | (irq_en_q[1] & tx_empty);
   end

   always_ff @(posedge clk or negedge rts_n) begin
      if (!rts_n) begin
         div_q       <= DIV_RESET;
         irq_en_q    <= '0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
         irq_q       <= 1'b0;
      end else begin
         div_q       <= div_d;
         irq_en_q    <= irq_en_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
         irq_q       <= irq_d;
      end
   end

   // ---------------------------------------------------------------- FIFOs
   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .rts_n (rts_n),
      .push  (tx_push),
      .din   (APB_pdata[7:0]),
      .pop   (tx_pop),
      .dout  (tx_dout),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_count)
   );

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk   (clk),
      .rts_n (rts_n),
      .push  (rx_push_q),
      .din   (rx_shift_q),
      .pop   (rx_pop),
      .dout  (rx_dout),
      .full  (rx_full),
      .empty (rx_empty),
      .count (rx_count)
   );

   // ---------------------------------------------------------------- TX engine
   assign tx_pop = (tx_state_q == TX_IDLE) & ~tx_empty;

   always_ff @(posedge clk or negedge rts_n) begin
      if (!rts_n) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_div_q   <= DIV_RESET;
         tx_shift_q <= '0;
         tx_bit_q   <= '0;
         uart_tx_q  <= 1'b1;
      end else begin
         case (tx_state_q)
            TX_IDLE: begin
               if (!tx_empty) begin
                  tx_state_q <= TX_START;
                  tx_div_q   <= div_q;
                  tx_cnt_q   <= div_q - 16'd1;
                  tx_shift_q <= tx_dout;
                  uart_tx_q  <= 1'b0;
               end
            end
            TX_START: begin
               if (tx_cnt_q == 16'd0) begin
                  tx_state_q <= TX_DATA;
                  tx_cnt_q   <= tx_div_q - 16'd1;
                  tx_bit_q   <= '0;
                  uart_tx_q  <= tx_shift_q[0];
               end else begin
                  tx_cnt_q <= tx_cnt_q - 16'd1;
               end
            end
            TX_DATA: begin
               if (tx_cnt_q == 16'd0) begin
                  tx_cnt_q <= tx_div_q - 16'd1;
                  if (tx_bit_q == 3'd7) begin
                     tx_state_q <= TX_STOP;
                     uart_tx_q  <= 1'b1;
                  end else begin
                     tx_bit_q   <= tx_bit_q + 3'd1;
                     tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                     uart_tx_q  <= tx_shift_q[1];
                  end
               end else begin
                  tx_cnt_q <= tx_cnt_q - 16'd1;
               end
            end
            TX_STOP: begin
               if (tx_cnt_q == 16'd0) tx_state_q <= TX_IDLE;
               else                   tx_cnt_q   <= tx_cnt_q - 16'd1;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------- RX engine
   always_ff @(posedge clk or negedge rts_n) begin
      if (!rts_n) begin
         rx_s1_q     <= 1'b1;
         rx_s2_q     <= 1'b1;
         rx_prev_q   <= 1'b1;
         rx_state_q  <= RX_IDLE;
         rx_cnt_q    <= '0;
         rx_div_q    <= DIV_RESET;
         rx_shift_q  <= '0;
         rx_bit_q    <= '0;
         rx_push_q   <= 1'b0;
         frame_set_q <= 1'b0;
      end else begin
         rx_s1_q     <= uart_rx;
         rx_s2_q     <= rx_s1_q;
         rx_prev_q   <= rx_s2_q;
         rx_push_q   <= 1'b0;
         frame_set_q <= 1'b0;
         case (rx_state_q)
            RX_IDLE: begin
               if (rx_prev_q && !rx_s2_q) begin
                  rx_state_q <= RX_START;
                  rx_div_q   <= div_q;
                  rx_cnt_q   <= {1'b0, div_q[15:1]} - 16'd1;
               end
            end
            RX_START: begin
               if (rx_cnt_q == 16'd0) begin
                  if (rx_s2_q) begin
                     rx_state_q <= RX_IDLE;
                  end else begin
                     rx_state_q <= RX_DATA;
                     rx_cnt_q   <= rx_div_q - 16'd1;
                     rx_bit_q   <= '0;
                  end
               end else begin
                  rx_cnt_q <= rx_cnt_q - 16'd1;
               end
            end
            RX_DATA: begin
               if (rx_cnt_q == 16'd0) begin
                  rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                  rx_cnt_q   <= rx_div_q - 16'd1;
                  if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                  else                  rx_bit_q   <= rx_bit_q + 3'd1;
               end else begin
                  rx_cnt_q <= rx_cnt_q - 16'd1;
               end
            end
            RX_STOP: begin
               if (rx_cnt_q == 16'd0) begin
                  rx_state_q <= RX_IDLE;
                  if (rx_s2_q) rx_push_q   <= 1'b1;
                  else         frame_set_q <= 1'b1;
               end else begin
                  rx_cnt_q <= rx_cnt_q - 16'd1;
               end
            end
         endcase
      end
   end

   assign uart_tx = uart_tx_q;
   assign irq     = irq_q;

   logic unused_ok;
   assign unused_ok = ^{APB_paddr, APB_pdata, APB_pstb, tx_count, rx_count};

endmodule
`default_nettype wire
